mult_9_stream_source: RTL and testbench

// - Transmit end of the multiplier_9 token protocol. Turns per-flux job descriptors plus raw samples into the

---
 rtl/mult_9_pkg.sv | 26 ++
 rtl/mult_9_stream_source_arbiter.sv | 35 +++
 rtl/mult_9_stream_source.sv | 136 +++++++++++++
 tb/tb_mult_9_stream_source.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_9_pkg.sv
// Shared widths, per-flux state type and job-length helper for the multiplier_9 token source.
package mult_9_pkg;

    localparam int FLUX_DEF  = 2;
    localparam int DATA_W    = 8;
    localparam int COEFF_W   = 9;
    localparam int EXT_W     = 7;
    localparam int TAG_W     = $clog2(FLUX_DEF);
    localparam int REM_WIDTH = 14;

    // Packed FIFO word widths: the flux tag always sits in the top bits.
    localparam int CFG_W = TAG_W + COEFF_W + EXT_W;
    localparam int SMP_W = TAG_W + DATA_W;
    localparam int B_W   = TAG_W + COEFF_W;
    localparam int X_W   = TAG_W + EXT_W;
    localparam int A_W   = TAG_W + DATA_W;

    typedef enum logic {IDLE, DATA} src_state_t;

    // Sample count of one job: s*(s+1)+1, matching the consumer's h/v loop.
    // Fits in 14 bits for every s <= 127 (max 16257).
    function automatic logic [REM_WIDTH-1:0] job_len(input logic [REM_WIDTH-1:0] s);
        return s * (s + REM_WIDTH'(1)) + REM_WIDTH'(1);
    endfunction

endpackage

// File: rtl/mult_9_stream_source_arbiter.sv
// Round-robin picker: first requesting flux at or after rr_ptr wins.
module flux_rr_arbiter #(
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = 1
) (
    input  logic [FLUX-1:0]      req,
    input  logic [TAG_WIDTH-1:0] rr_ptr,
    output logic [FLUX-1:0]      grant,
    output logic [TAG_WIDTH-1:0] tag,
    output logic                 valid
);

    int                   idx;
    logic [TAG_WIDTH-1:0] idx_t;

    // Scan the request vector starting at rr_ptr, wrapping modulo FLUX.
    always_comb begin
        grant = '0;
        tag   = '0;
        valid = 1'b0;
        idx   = 0;
        idx_t = '0;
        for (int k = 0; k < FLUX; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= FLUX) idx = idx - FLUX;
            idx_t = TAG_WIDTH'(idx);
            if (!valid && req[idx_t]) begin
                valid        = 1'b1;
                tag          = idx_t;
                grant[idx_t] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_9_stream_source.sv
// Token source for multiplier_9: per-flux job descriptors become a B/ext header pair,
// followed by N = s*(s+1)+1 tagged A tokens. One flux is served per cycle, round-robin.
// Handshake: a read[i] or write pulse means the transfer happens on this rising edge;
// din/dout are valid only in that same cycle (combinational FIFO-head pass-through).
module mult_9_stream_source
    import mult_9_pkg::*;
#(
    parameter int FLUX            = FLUX_DEF,
    parameter int DATA_WIDTH      = DATA_W,
    parameter int DATA_WIDTH_OP_B = COEFF_W,
    parameter int DATA_WIDTH_EXT  = EXT_W,
    localparam int TAG_WIDTH      = $clog2(FLUX),
    localparam int CW             = TAG_WIDTH + DATA_WIDTH_OP_B + DATA_WIDTH_EXT,
    localparam int SW             = TAG_WIDTH + DATA_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [FLUX-1:0]                      read_port_cfg_empty,
    output logic [FLUX-1:0]                      read_port_cfg_read,
    input  logic [FLUX-1:0][CW-1:0]              read_port_cfg_dout,
    input  logic [FLUX-1:0]                      read_port_smp_empty,
    output logic [FLUX-1:0]                      read_port_smp_read,
    input  logic [FLUX-1:0][SW-1:0]              read_port_smp_dout,
    output logic                                 write_port_B_write,
    output logic [TAG_WIDTH+DATA_WIDTH_OP_B-1:0] write_port_B_din,
    input  logic                                 write_port_B_full,
    output logic                                 write_port_ext_size_write,
    output logic [TAG_WIDTH+DATA_WIDTH_EXT-1:0]  write_port_ext_size_din,
    input  logic                                 write_port_ext_size_full,
    output logic                                 write_port_A_write,
    output logic [TAG_WIDTH+DATA_WIDTH-1:0]      write_port_A_din,
    input  logic                                 write_port_A_full,
    output logic [FLUX-1:0]                      dbg_busy,
    output logic [FLUX-1:0][REM_WIDTH-1:0]       dbg_rem,
    output logic [TAG_WIDTH-1:0]                 dbg_rr_ptr
);

    src_state_t           state_q [FLUX];
    src_state_t           state_d [FLUX];
    logic [REM_WIDTH-1:0] rem_q   [FLUX];
    logic [REM_WIDTH-1:0] rem_d   [FLUX];
    logic [TAG_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    logic [FLUX-1:0]      req;
    logic [FLUX-1:0]      gnt;
    logic [TAG_WIDTH-1:0] gnt_tag;
    logic                 gnt_valid;
    logic                 unused_tag_bits;

    // A flux may request only when every FIFO it would touch this cycle can take the transfer.
    always_comb begin
        for (int i = 0; i < FLUX; i++) begin
            req[i] = 1'b0;
            if (rst) begin
                if (state_q[i] == IDLE)
                    req[i] = !read_port_cfg_empty[i] && !write_port_B_full && !write_port_ext_size_full;
                else
                    req[i] = !read_port_smp_empty[i] && !write_port_A_full;
            end
        end
    end

    flux_rr_arbiter #(.FLUX(FLUX), .TAG_WIDTH(TAG_WIDTH)) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .grant  (gnt),
        .tag    (gnt_tag),
        .valid  (gnt_valid)
    );

    // Granted flux: header or sample transfer plus its next state; all other fluxes hold.
    always_comb begin
        read_port_cfg_read        = '0;
        read_port_smp_read        = '0;
        write_port_B_write        = 1'b0;
        write_port_B_din          = 'x;
        write_port_ext_size_write = 1'b0;
        write_port_ext_size_din   = 'x;
        write_port_A_write        = 1'b0;
        write_port_A_din          = 'x;
        rr_ptr_d                  = rr_ptr_q;
        for (int i = 0; i < FLUX; i++) begin
            state_d[i] = state_q[i];
            rem_d[i]   = rem_q[i];
        end
        if (gnt_valid) begin
            rr_ptr_d = (gnt_tag == TAG_WIDTH'(FLUX - 1)) ? '0 : gnt_tag + TAG_WIDTH'(1);
            if (state_q[gnt_tag] == IDLE) begin
                read_port_cfg_read        = gnt;
                write_port_B_write        = 1'b1;
                write_port_B_din          = {gnt_tag,
                    read_port_cfg_dout[gnt_tag][DATA_WIDTH_OP_B+DATA_WIDTH_EXT-1:DATA_WIDTH_EXT]};
                write_port_ext_size_write = 1'b1;
                write_port_ext_size_din   = {gnt_tag, read_port_cfg_dout[gnt_tag][DATA_WIDTH_EXT-1:0]};
                rem_d[gnt_tag]   = job_len(REM_WIDTH'(read_port_cfg_dout[gnt_tag][DATA_WIDTH_EXT-1:0]));
                state_d[gnt_tag] = DATA;
            end else begin
                read_port_smp_read = gnt;
                write_port_A_write = 1'b1;
                write_port_A_din   = {gnt_tag, read_port_smp_dout[gnt_tag][DATA_WIDTH-1:0]};
                rem_d[gnt_tag]     = rem_q[gnt_tag] - REM_WIDTH'(1);
                if (rem_q[gnt_tag] == REM_WIDTH'(1)) state_d[gnt_tag] = IDLE;
            end
        end
    end

    // Per-flux state, remaining count and round-robin pointer; reset abandons partial jobs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < FLUX; i++) begin
                state_q[i] <= IDLE;
                rem_q[i]   <= '0;
            end
            rr_ptr_q <= '0;
        end else begin
            for (int i = 0; i < FLUX; i++) begin
                state_q[i] <= state_d[i];
                rem_q[i]   <= rem_d[i];
            end
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Debug view of the per-flux FSMs; the tag copies inside FIFO words are redundant with the index.
    always_comb begin
        unused_tag_bits = 1'b0;
        for (int i = 0; i < FLUX; i++) begin
            dbg_busy[i]     = (state_q[i] == DATA);
            dbg_rem[i]      = rem_q[i];
            unused_tag_bits = unused_tag_bits ^ (^read_port_cfg_dout[i][CW-1:CW-TAG_WIDTH])
                                              ^ (^read_port_smp_dout[i][SW-1:SW-TAG_WIDTH]);
        end
        dbg_rr_ptr = rr_ptr_q;
    end

endmodule

// File: tb/tb_mult_9_stream_source.sv
// Directed bench for mult_9_stream_source: queue-modelled input FIFOs, per-flux expected
// token queues, and a negedge monitor that pops and compares every write.
module tb_mult_9_stream_source;
  import mult_9_pkg::*;

  localparam int F = FLUX_DEF;

  logic clk;
  logic rst;
  logic [F-1:0]              cfg_empty, cfg_read, smp_empty, smp_read;
  logic [F-1:0][CFG_W-1:0]   cfg_dout;
  logic [F-1:0][SMP_W-1:0]   smp_dout;
  logic                      b_write, x_write, a_write;
  logic [B_W-1:0]            b_din;
  logic [X_W-1:0]            x_din;
  logic [A_W-1:0]            a_din;
  logic                      b_full, x_full, a_full;
  logic [F-1:0]              dbg_busy;
  logic [F-1:0][REM_WIDTH-1:0] dbg_rem;
  logic [TAG_W-1:0]          dbg_rr_ptr;

  logic [CFG_W-1:0] cfg_fifo [F][$];
  logic [SMP_W-1:0] smp_fifo [F][$];
  logic [B_W-1:0]   exp_b_q  [F][$];
  logic [X_W-1:0]   exp_x_q  [F][$];
  logic [A_W-1:0]   exp_a_q  [F][$];

  int n_checks;
  int n_fail;
  bit rr_mode;
  bit prev_a_valid;
  logic [TAG_W-1:0] prev_a_tag;
  int reads_seen;

  mult_9_stream_source dut (
    .clk                       (clk),
    .rst                       (rst),
    .read_port_cfg_empty       (cfg_empty),
    .read_port_cfg_read        (cfg_read),
    .read_port_cfg_dout        (cfg_dout),
    .read_port_smp_empty       (smp_empty),
    .read_port_smp_read        (smp_read),
    .read_port_smp_dout        (smp_dout),
    .write_port_B_write        (b_write),
    .write_port_B_din          (b_din),
    .write_port_B_full         (b_full),
    .write_port_ext_size_write (x_write),
    .write_port_ext_size_din   (x_din),
    .write_port_ext_size_full  (x_full),
    .write_port_A_write        (a_write),
    .write_port_A_din          (a_din),
    .write_port_A_full         (a_full),
    .dbg_busy                  (dbg_busy),
    .dbg_rem                   (dbg_rem),
    .dbg_rr_ptr                (dbg_rr_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic refresh();
    for (int i = 0; i < F; i++) begin
      cfg_empty[i] = (cfg_fifo[i].size() == 0);
      cfg_dout[i]  = cfg_empty[i] ? '0 : cfg_fifo[i][0];
      smp_empty[i] = (smp_fifo[i].size() == 0);
      smp_dout[i]  = smp_empty[i] ? '0 : smp_fifo[i][0];
    end
  endtask

  task automatic tick();
    logic [F-1:0] rc, rs;
    @(negedge clk);
    rc = cfg_read;
    rs = smp_read;
    if ((rc | rs) != '0) reads_seen++;
    if (rr_mode) begin
      if (a_write) begin
        if (prev_a_valid) check("rr_alternate", 32'(a_din[A_W-1 -: TAG_W] != prev_a_tag), 32'd1);
        prev_a_valid = 1'b1;
        prev_a_tag   = a_din[A_W-1 -: TAG_W];
      end else begin
        prev_a_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < F; i++) begin
      if (rc[i]) begin
        if (cfg_fifo[i].size() == 0) check("cfg_read_empty", 32'd1, 32'd0);
        else void'(cfg_fifo[i].pop_front());
      end
      if (rs[i]) begin
        if (smp_fifo[i].size() == 0) check("smp_read_empty", 32'd1, 32'd0);
        else void'(smp_fifo[i].pop_front());
      end
    end
    refresh();
  endtask

  task automatic push_job(input int f, input logic [COEFF_W-1:0] coeff, input logic [EXT_W-1:0] s);
    logic [TAG_W-1:0] t;
    t = TAG_W'(f);
    cfg_fifo[f].push_back({t, coeff, s});
    exp_b_q[f].push_back({t, coeff});
    exp_x_q[f].push_back({t, s});
    refresh();
  endtask

  task automatic push_smp(input int f, input logic [DATA_W-1:0] v, input bit expect_out);
    logic [TAG_W-1:0] t;
    t = TAG_W'(f);
    smp_fifo[f].push_back({t, v});
    if (expect_out) exp_a_q[f].push_back({t, v});
    refresh();
  endtask

  function automatic bit all_drained();
    for (int i = 0; i < F; i++)
      if (exp_b_q[i].size() != 0 || exp_x_q[i].size() != 0 || exp_a_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int cnt;
    cnt = 0;
    while (!all_drained() && cnt < budget) begin
      tick();
      cnt++;
    end
    check(name, 32'(all_drained()), 32'd1);
  endtask

  // scoreboard monitor: compares every output write against the per-flux expected queues
  initial begin
    logic [TAG_W-1:0] t;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("reset_quiet", 32'({cfg_read, smp_read, b_write, x_write, a_write}), 32'd0);
      end else begin
        check("read_onehot", 32'($countones({cfg_read, smp_read}) <= 1), 32'd1);
        if (b_write || x_write) check("b_ext_pair", 32'(b_write), 32'(x_write));
        if (b_write) check("cfg_read_with_b", 32'(cfg_read != '0), 32'd1);
        if (b_write) begin
          t = b_din[B_W-1 -: TAG_W];
          if (exp_b_q[t].size() == 0) check("b_unexpected", 32'(b_din), 32'hFFFF_FFFF);
          else check("b_token", 32'(b_din), 32'(exp_b_q[t].pop_front()));
        end
        if (x_write) begin
          t = x_din[X_W-1 -: TAG_W];
          if (exp_x_q[t].size() == 0) check("ext_unexpected", 32'(x_din), 32'hFFFF_FFFF);
          else check("ext_token", 32'(x_din), 32'(exp_x_q[t].pop_front()));
        end
        if (a_write) begin
          t = a_din[A_W-1 -: TAG_W];
          if (exp_a_q[t].size() == 0) check("a_unexpected", 32'(a_din), 32'hFFFF_FFFF);
          else check("a_token", 32'(a_din), 32'(exp_a_q[t].pop_front()));
        end
      end
    end
  end

  // directed stimulus
  initial begin
    int cnt;
    logic [REM_WIDTH-1:0] rem_snap;
    n_checks = 0;
    n_fail = 0;
    rr_mode = 1'b0;
    prev_a_valid = 1'b0;
    prev_a_tag = '0;
    reads_seen = 0;
    b_full = 1'b0;
    x_full = 1'b0;
    a_full = 1'b0;
    rst = 1'b0;
    refresh();

    // reset and idle
    repeat (3) tick();
    check("reset_busy", 32'(dbg_busy), 32'd0);
    check("reset_rem0", 32'(dbg_rem[0]), 32'd0);
    check("reset_rem1", 32'(dbg_rem[1]), 32'd0);
    check("reset_rr", 32'(dbg_rr_ptr), 32'd0);
    rst = 1'b1;
    repeat (2) tick();
    check("idle_busy", 32'(dbg_busy), 32'd0);

    // single job: coeff=-3, s=3 -> 13 samples; 14th must stay
    push_job(0, 9'h1FD, 7'd3);
    for (int k = 1; k <= 13; k++) push_smp(0, 8'(k), 1'b1);
    push_smp(0, 8'd14, 1'b0);
    wait_drain("single_job_drain", 40);
    repeat (2) tick();
    check("single_leftover", 32'(smp_fifo[0].size()), 32'd1);
    check("single_idle", 32'(dbg_busy[0]), 32'd0);
    smp_fifo[0].delete();
    refresh();

    // s=0 job on flux1
    push_job(1, 9'h0FF, 7'd0);
    push_smp(1, 8'hA5, 1'b1);
    wait_drain("s0_drain", 10);
    check("s0_idle", 32'(dbg_busy[1]), 32'd0);
    check("s0_rem", 32'(dbg_rem[1]), 32'd0);

    // round-robin: both fluxes with s=1 (3 samples each)
    rr_mode = 1'b1;
    push_job(0, 9'h010, 7'd1);
    push_job(1, 9'h020, 7'd1);
    for (int k = 0; k < 3; k++) begin
      push_smp(0, 8'(8'h30 + k), 1'b1);
      push_smp(1, 8'(8'h40 + k), 1'b1);
    end
    wait_drain("rr_drain", 20);
    rr_mode = 1'b0;

    // back-pressure on A mid-job: s=2 -> 7 samples
    push_job(0, 9'h155, 7'd2);
    for (int k = 0; k < 7; k++) push_smp(0, 8'(8'h60 + k), 1'b1);
    cnt = 0;
    while (exp_a_q[0].size() > 4 && cnt < 20) begin tick(); cnt++; end
    check("bp_reached", 32'(exp_a_q[0].size()), 32'd4);
    a_full = 1'b1;
    rem_snap = dbg_rem[0];
    reads_seen = 0;
    repeat (5) tick();
    check("bp_no_reads", 32'(reads_seen), 32'd0);
    check("bp_rem_hold", 32'(dbg_rem[0]), 32'(rem_snap));
    check("bp_rem_val", 32'(rem_snap), 32'd4);
    check("bp_fifo_hold", 32'(smp_fifo[0].size()), 32'd4);
    a_full = 1'b0;
    wait_drain("bp_drain", 20);

    // ext_size full while cfg pending
    x_full = 1'b1;
    push_job(1, 9'h1AA, 7'd0);
    push_smp(1, 8'h5A, 1'b1);
    reads_seen = 0;
    repeat (4) tick();
    check("xfull_no_reads", 32'(reads_seen), 32'd0);
    check("xfull_idle", 32'(dbg_busy[1]), 32'd0);
    check("xfull_cfg_hold", 32'(cfg_fifo[1].size()), 32'd1);
    x_full = 1'b0;
    wait_drain("xfull_drain", 10);

    // largest job length: s=127 -> 16257 (header only, abandoned by the reset below)
    push_job(1, 9'h001, 7'd127);
    cnt = 0;
    while (!dbg_busy[1] && cnt < 10) begin tick(); cnt++; end
    check("s127_rem", 32'(dbg_rem[1]), 32'd16257);

    // reset mid-job after 5 of 13 tokens
    push_job(0, 9'h003, 7'd3);
    for (int k = 0; k < 13; k++) push_smp(0, 8'(8'h80 + k), 1'b1);
    cnt = 0;
    while (exp_a_q[0].size() > 8 && cnt < 20) begin tick(); cnt++; end
    check("rst_mid_reached", 32'(exp_a_q[0].size()), 32'd8);
    rst = 1'b0;
    repeat (2) tick();
    check("rst_mid_busy", 32'(dbg_busy), 32'd0);
    check("rst_mid_rem0", 32'(dbg_rem[0]), 32'd0);
    check("rst_mid_rem1", 32'(dbg_rem[1]), 32'd0);
    for (int i = 0; i < F; i++) begin
      cfg_fifo[i].delete();
      smp_fifo[i].delete();
      exp_b_q[i].delete();
      exp_x_q[i].delete();
      exp_a_q[i].delete();
    end
    refresh();
    rst = 1'b1;
    push_job(0, 9'h1F0, 7'd3);
    for (int k = 0; k < 13; k++) push_smp(0, 8'(8'hC0 + k), 1'b1);
    cnt = 0;
    while (!dbg_busy[0] && cnt < 10) begin tick(); cnt++; end
    check("rst_new_rem", 32'(dbg_rem[0]), 32'd13);
    wait_drain("rst_new_drain", 40);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
